// File: rtl/rob_commit_unit_pkg.sv
// Shared definitions for the reorder buffer: entry-type encodings, ROB/register id widths
// and boolean constants.
package rob_commit_unit_pkg;

    localparam int unsigned RobIdW = 4;  // ROB entry name width
    localparam int unsigned RegIdW = 5;  // architectural register id width

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    // Encoding 3 is reserved and retires exactly like RobReg.
    typedef enum logic [1:0] {
        RobReg    = 2'd0,
        RobStore  = 2'd1,
        RobBranch = 2'd2,
        RobRsvd   = 2'd3
    } rob_type_e;

endpackage

// File: rtl/rob_lookup_port.sv
// One operand-lookup port of the reorder buffer (purely combinational).
//
// Build option: define ROB_BYPASS_EN to also forward a same-cycle ALU/LSB writeback that
// targets the looked-up busy entry (ALU wins over LSB). Undefined: registered state only.
//
// Ports:
//   ord_i                      entry name being looked up
//   busy_i / ready_i / value_i registered per-entry state
//   alu_* / lsb_*              writeback buses (used only for bypass)
//   rdy_o                      entry busy and value ready
//   val_o                      value when rdy_o, else 0
module rob_lookup_port
    import rob_commit_unit_pkg::*;
#(
    parameter int unsigned ROB_SIZE_LOG = RobIdW,
    parameter int unsigned ROB_SIZE     = 2 ** ROB_SIZE_LOG
) (
    input  logic [ROB_SIZE_LOG-1:0]    ord_i,
    input  logic [ROB_SIZE-1:0]        busy_i,
    input  logic [ROB_SIZE-1:0]        ready_i,
    input  logic [ROB_SIZE-1:0][31:0]  value_i,
    input  logic                       alu_sgn_i,
    input  logic [ROB_SIZE_LOG-1:0]    alu_name_i,
    input  logic [31:0]                alu_val_i,
    input  logic                       lsb_sgn_i,
    input  logic [ROB_SIZE_LOG-1:0]    lsb_name_i,
    input  logic [31:0]                lsb_val_i,
    output logic                       rdy_o,
    output logic [31:0]                val_o
);

    always_comb begin
        rdy_o = busy_i[ord_i] && ready_i[ord_i];
        val_o = rdy_o ? value_i[ord_i] : 32'd0;
`ifdef ROB_BYPASS_EN
        if (busy_i[ord_i]) begin
            if (alu_sgn_i && (alu_name_i == ord_i)) begin
                rdy_o = True;
                val_o = alu_val_i;
            end else if (lsb_sgn_i && (lsb_name_i == ord_i)) begin
                rdy_o = True;
                val_o = lsb_val_i;
            end
        end
`endif
    end

`ifndef ROB_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{alu_sgn_i, alu_name_i, alu_val_i, lsb_sgn_i, lsb_name_i, lsb_val_i};
`endif

endmodule

// File: rtl/rob_commit_unit.sv
// 16-entry circular reorder buffer: in-order allocation at issue, result capture from the
// ALU/LSB buses, two operand-lookup ports, and in-order retirement of one entry per cycle
// (register commit, store release, or branch-mispredict flush with PC redirect).
//
// Build option: ROB_BYPASS_EN (see rob_lookup_port) adds same-cycle writeback forwarding.
//
// Ports:
//   clk, rst_n, rdy            clock, async active-low reset, global enable
//   IS_*                       issue request; ROB_name is the granted name, ROB_full blocks it
//   ALU_* / LSB_*              result broadcasts (ALU also carries branch outcome / next PC)
//   ROB_ord*/ROB_rdy*/ROB_val* operand lookups for the register file
//   ROB_commit_*               registered register-commit strobe and payload
//   LSB_store_*                registered store-release strobe and name
//   clr, clr_pc                registered flush strobe and redirect PC
module rob_commit_unit
    import rob_commit_unit_pkg::*;
#(
    parameter int unsigned ROB_SIZE_LOG = RobIdW,
    parameter int unsigned ROB_SIZE     = 2 ** ROB_SIZE_LOG
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    input  logic                     IS_sgn,
    input  logic [1:0]               IS_type,
    input  logic [RegIdW-1:0]        IS_dest,
    input  logic                     IS_pred,
    output logic [ROB_SIZE_LOG-1:0]  ROB_name,
    output logic                     ROB_full,
    input  logic                     ALU_sgn,
    input  logic [ROB_SIZE_LOG-1:0]  ALU_name,
    input  logic [31:0]              ALU_val,
    input  logic                     ALU_taken,
    input  logic [31:0]              ALU_npc,
    input  logic                     LSB_sgn,
    input  logic [ROB_SIZE_LOG-1:0]  LSB_name,
    input  logic [31:0]              LSB_val,
    input  logic [ROB_SIZE_LOG-1:0]  ROB_ord1,
    input  logic [ROB_SIZE_LOG-1:0]  ROB_ord2,
    output logic                     ROB_rdy1,
    output logic                     ROB_rdy2,
    output logic [31:0]              ROB_val1,
    output logic [31:0]              ROB_val2,
    output logic                     ROB_commit_sgn,
    output logic [RegIdW-1:0]        ROB_commit_dest,
    output logic [31:0]              ROB_commit_value,
    output logic [ROB_SIZE_LOG-1:0]  ROB_commit_ROB_name,
    output logic                     LSB_store_sgn,
    output logic [ROB_SIZE_LOG-1:0]  LSB_store_name,
    output logic                     clr,
    output logic [31:0]              clr_pc
);

    localparam int unsigned CntW = ROB_SIZE_LOG + 1;

    // Per-entry state
    logic [ROB_SIZE-1:0]              busy_q, busy_d, ready_q, ready_d;
    logic [ROB_SIZE-1:0]              pred_q, pred_d, taken_q, taken_d;
    logic [ROB_SIZE-1:0][1:0]         type_q, type_d;
    logic [ROB_SIZE-1:0][RegIdW-1:0]  dest_q, dest_d;
    logic [ROB_SIZE-1:0][31:0]        value_q, value_d, npc_q, npc_d;
    logic [ROB_SIZE_LOG-1:0]          head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]                  count_q, count_d;

    // Registered outputs
    logic                     commit_sgn_q, commit_sgn_d, store_sgn_q, store_sgn_d;
    logic                     clr_q, clr_d;
    logic [RegIdW-1:0]        commit_dest_q, commit_dest_d;
    logic [31:0]              commit_value_q, commit_value_d, clr_pc_q, clr_pc_d;
    logic [ROB_SIZE_LOG-1:0]  commit_name_q, commit_name_d, store_name_q, store_name_d;

    logic do_commit, do_issue, mispredict, head_is_store, head_is_branch;

    assign ROB_full = (count_q == CntW'(ROB_SIZE));
    assign ROB_name = tail_q;

    assign do_commit      = (count_q != '0) && busy_q[head_q] && ready_q[head_q];
    assign head_is_store  = (type_q[head_q] == RobStore);
    assign head_is_branch = (type_q[head_q] == RobBranch);
    assign mispredict     = do_commit && head_is_branch && (taken_q[head_q] != pred_q[head_q]);
    // Issue is dropped while full, on the flush edge, and in the cycle clr is visible.
    assign do_issue       = IS_sgn && !ROB_full && !clr_q && !mispredict;

    always_comb begin
        busy_d         = busy_q;
        ready_d        = ready_q;
        pred_d         = pred_q;
        taken_d        = taken_q;
        type_d         = type_q;
        dest_d         = dest_q;
        value_d        = value_q;
        npc_d          = npc_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_sgn_d   = False;
        store_sgn_d    = False;
        clr_d          = False;
        commit_dest_d  = commit_dest_q;
        commit_value_d = commit_value_q;
        commit_name_d  = commit_name_q;
        store_name_d   = store_name_q;
        clr_pc_d       = clr_pc_q;

        // Writebacks only land on allocated entries.
        if (ALU_sgn && busy_q[ALU_name]) begin
            ready_d[ALU_name] = True;
            value_d[ALU_name] = ALU_val;
            if (type_q[ALU_name] == RobBranch) begin
                taken_d[ALU_name] = ALU_taken;
                npc_d[ALU_name]   = ALU_npc;
            end
        end
        if (LSB_sgn && busy_q[LSB_name]) begin
            ready_d[LSB_name] = True;
            value_d[LSB_name] = LSB_val;
        end

        if (do_commit) begin
            if (head_is_store) begin
                store_sgn_d  = True;
                store_name_d = head_q;
            end else begin
                commit_sgn_d   = True;
                commit_dest_d  = dest_q[head_q];
                commit_value_d = value_q[head_q];
                commit_name_d  = head_q;
            end
            busy_d[head_q]  = False;
            ready_d[head_q] = False;
            head_d          = head_q + ROB_SIZE_LOG'(1);
        end

        if (do_issue) begin
            busy_d[tail_q]  = True;
            ready_d[tail_q] = False;
            type_d[tail_q]  = IS_type;
            dest_d[tail_q]  = IS_dest;
            pred_d[tail_q]  = IS_pred;
            tail_d          = tail_q + ROB_SIZE_LOG'(1);
        end

        case ({do_issue, do_commit})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // Flush overrides every other state update on this edge except the rd commit.
        if (mispredict) begin
            busy_d   = '0;
            ready_d  = '0;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            clr_d    = True;
            clr_pc_d = npc_q[head_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q         <= '0;
            ready_q        <= '0;
            pred_q         <= '0;
            taken_q        <= '0;
            type_q         <= '0;
            dest_q         <= '0;
            value_q        <= '0;
            npc_q          <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_sgn_q   <= 1'b0;
            store_sgn_q    <= 1'b0;
            clr_q          <= 1'b0;
            commit_dest_q  <= '0;
            commit_value_q <= '0;
            commit_name_q  <= '0;
            store_name_q   <= '0;
            clr_pc_q       <= '0;
        end else if (rdy) begin
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            pred_q         <= pred_d;
            taken_q        <= taken_d;
            type_q         <= type_d;
            dest_q         <= dest_d;
            value_q        <= value_d;
            npc_q          <= npc_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_sgn_q   <= commit_sgn_d;
            store_sgn_q    <= store_sgn_d;
            clr_q          <= clr_d;
            commit_dest_q  <= commit_dest_d;
            commit_value_q <= commit_value_d;
            commit_name_q  <= commit_name_d;
            store_name_q   <= store_name_d;
            clr_pc_q       <= clr_pc_d;
        end
    end

    assign ROB_commit_sgn      = commit_sgn_q;
    assign ROB_commit_dest     = commit_dest_q;
    assign ROB_commit_value    = commit_value_q;
    assign ROB_commit_ROB_name = commit_name_q;
    assign LSB_store_sgn       = store_sgn_q;
    assign LSB_store_name      = store_name_q;
    assign clr                 = clr_q;
    assign clr_pc              = clr_pc_q;

    rob_lookup_port #(
        .ROB_SIZE_LOG (ROB_SIZE_LOG),
        .ROB_SIZE     (ROB_SIZE)
    ) u_lookup1 (
        .ord_i      (ROB_ord1),
        .busy_i     (busy_q),
        .ready_i    (ready_q),
        .value_i    (value_q),
        .alu_sgn_i  (ALU_sgn),
        .alu_name_i (ALU_name),
        .alu_val_i  (ALU_val),
        .lsb_sgn_i  (LSB_sgn),
        .lsb_name_i (LSB_name),
        .lsb_val_i  (LSB_val),
        .rdy_o      (ROB_rdy1),
        .val_o      (ROB_val1)
    );

    rob_lookup_port #(
        .ROB_SIZE_LOG (ROB_SIZE_LOG),
        .ROB_SIZE     (ROB_SIZE)
    ) u_lookup2 (
        .ord_i      (ROB_ord2),
        .busy_i     (busy_q),
        .ready_i    (ready_q),
        .value_i    (value_q),
        .alu_sgn_i  (ALU_sgn),
        .alu_name_i (ALU_name),
        .alu_val_i  (ALU_val),
        .lsb_sgn_i  (LSB_sgn),
        .lsb_name_i (LSB_name),
        .lsb_val_i  (LSB_val),
        .rdy_o      (ROB_rdy2),
        .val_o      (ROB_val2)
    );

endmodule
